// File: rtl/fcb_rfu_rd_pkg.sv
// Shared types and helpers for the FCB register-file FIFO read serializer.
package fcb_rfu_rd_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    MODE_B8  = 2'b00,
    MODE_B16 = 2'b01,
    MODE_B32 = 2'b10
  } mode_t;

  function automatic logic [2:0] beats_per_word(mode_t m);
    logic [2:0] n;
    case (m)
      MODE_B8:  n = 3'd4;
      MODE_B16: n = 3'd2;
      default:  n = 3'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/fcb_rfu_lane_mux.sv
// Combinational beat select: picks the byte/halfword/word slot for the current lane.
module fcb_rfu_lane_mux
  import fcb_rfu_rd_pkg::*;
(
  input  logic [31:0] hold_i,
  input  mode_t       mode_i,
  input  logic        endian_i,
  input  logic [1:0]  lane_i,
  output logic [31:0] beat_o
);

  logic [1:0] slot8;
  logic       slot16;

  // Big-endian walks the slots from the top: slot = N-1-k is the bitwise inverse of k.
  assign slot8  = endian_i ? ~lane_i : lane_i;
  assign slot16 = endian_i ? ~lane_i[0] : lane_i[0];

  always_comb begin
    beat_o = '0;
    case (mode_i)
      MODE_B8:  beat_o[7:0]  = hold_i[{slot8, 3'b000} +: 8];
      MODE_B16: beat_o[15:0] = hold_i[{slot16, 4'b0000} +: 16];
      default:  beat_o       = hold_i;
    endcase
  end

endmodule

// File: rtl/fcb_rfu_rd_serializer.sv
// Drains 32-bit words from the register-file FIFO and emits them as 1/2/4-byte beats
// over a valid/ready handshake.
module fcb_rfu_rd_serializer
  import fcb_rfu_rd_pkg::*;
#(
  parameter int PAR_FIFO_DATA_WIDTH = 32,
  parameter int PAR_WCNT_WIDTH      = 16
) (
  input  logic                           fifo_clk,
  input  logic                           fifo_rst_n,
  input  logic [PAR_FIFO_DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                           fifo_empty_flag,
  output logic                           fifo_rd_en,
  input  logic [1:0]                     cfg_mode,
  input  logic                           cfg_big_endian,
  input  logic                           flush,
  output logic [31:0]                    ser_data,
  output logic                           ser_valid,
  input  logic                           ser_ready,
  output logic                           ser_last,
  output logic [PAR_WCNT_WIDTH-1:0]      word_cnt,
  output logic                           busy
);

  if (PAR_FIFO_DATA_WIDTH != 32) begin : g_width_check
    $error("fcb_rfu_rd_serializer: PAR_FIFO_DATA_WIDTH must be 32");
  end

  state_t                    state_q, state_d;
  logic [31:0]               hold_q, hold_d;
  logic [1:0]                lane_q, lane_d;
  mode_t                     mode_q, mode_d;
  logic                      endian_q, endian_d;
  logic [PAR_WCNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]               ser_data_q, ser_data_d;
  logic                      ser_last_q, ser_last_d;

  logic        accept;
  logic        last_acc;
  logic        load;
  logic [31:0] beat_nxt;

  assign ser_valid = (state_q == ST_SEND);
  assign accept    = ser_valid & ser_ready;
  assign last_acc  = accept & ser_last_q;
  assign load      = !flush && !fifo_empty_flag && ((state_q == ST_IDLE) || last_acc);

  // Gated by reset so no pop can escape while the FIFO itself is held in reset.
  assign fifo_rd_en = load & fifo_rst_n;

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    lane_d   = lane_q;
    mode_d   = mode_q;
    endian_d = endian_q;
    cnt_d    = cnt_q;
    if (flush) begin
      state_d = ST_IDLE;
      lane_d  = '0;
    end else begin
      if (last_acc) begin
        cnt_d   = cnt_q + 1'b1;
        state_d = ST_IDLE;
        lane_d  = '0;
      end else if (accept) begin
        lane_d = lane_q + 2'd1;
      end
      if (load) begin
        state_d  = ST_SEND;
        hold_d   = fifo_rd_data;
        lane_d   = '0;
        mode_d   = (cfg_mode == 2'b11) ? MODE_B32 : mode_t'(cfg_mode);
        endian_d = cfg_big_endian;
      end
    end
  end

  // Beat is selected from next-state values so ser_data/ser_last can be registered.
  fcb_rfu_lane_mux u_lane_mux (
    .hold_i   (hold_d),
    .mode_i   (mode_d),
    .endian_i (endian_d),
    .lane_i   (lane_d),
    .beat_o   (beat_nxt)
  );

  always_comb begin
    ser_data_d = '0;
    ser_last_d = 1'b0;
    if (state_d == ST_SEND) begin
      ser_data_d = beat_nxt;
      ser_last_d = ({1'b0, lane_d} == (beats_per_word(mode_d) - 3'd1));
    end
  end

  always_ff @(posedge fifo_clk or negedge fifo_rst_n) begin
    if (!fifo_rst_n) begin
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      lane_q     <= '0;
      mode_q     <= MODE_B8;
      endian_q   <= 1'b0;
      cnt_q      <= '0;
      ser_data_q <= '0;
      ser_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      lane_q     <= lane_d;
      mode_q     <= mode_d;
      endian_q   <= endian_d;
      cnt_q      <= cnt_d;
      ser_data_q <= ser_data_d;
      ser_last_q <= ser_last_d;
    end
  end

  assign ser_data = ser_data_q;
  assign ser_last = ser_last_q;
  assign word_cnt = cnt_q;
  assign busy     = ser_valid | !fifo_empty_flag;

endmodule

// File: tb/tb_fcb_rfu_rd_serializer.sv
// Self-checking bench: table vectors, hand-written corner sequences and a randomized
// run checked against a queue-based beat model.
module tb_fcb_rfu_rd_serializer;

  logic        fifo_clk = 1'b0;
  logic        fifo_rst_n = 1'b0;
  logic [31:0] fifo_rd_data;
  logic        fifo_empty_flag;
  logic        fifo_rd_en;
  logic [1:0]  cfg_mode;
  logic        cfg_big_endian;
  logic        flush;
  logic [31:0] ser_data;
  logic        ser_valid;
  logic        ser_ready;
  logic        ser_last;
  logic [15:0] word_cnt;
  logic        busy;

  always #5 fifo_clk = ~fifo_clk;

  fcb_rfu_rd_serializer #(
    .PAR_FIFO_DATA_WIDTH (32),
    .PAR_WCNT_WIDTH      (16)
  ) dut (
    .fifo_clk        (fifo_clk),
    .fifo_rst_n      (fifo_rst_n),
    .fifo_rd_data    (fifo_rd_data),
    .fifo_empty_flag (fifo_empty_flag),
    .fifo_rd_en      (fifo_rd_en),
    .cfg_mode        (cfg_mode),
    .cfg_big_endian  (cfg_big_endian),
    .flush           (flush),
    .ser_data        (ser_data),
    .ser_valid       (ser_valid),
    .ser_ready       (ser_ready),
    .ser_last        (ser_last),
    .word_cnt        (word_cnt),
    .busy            (busy)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  typedef struct packed {
    logic [1:0]       mode;
    logic             be;
    logic [31:0]      word;
    logic [2:0]       n;
    logic [3:0][31:0] b;
  } vec_t;

  int          total = 0;
  int          bad = 0;
  int          pops = 0;
  logic [31:0] fifo_q[$];
  beat_t       got[$];
  beat_t       expq[$];
  vec_t        vecs[6];
  logic [15:0] exp_cnt = '0;

  logic        s_pop, s_valid, s_acc, s_last, s_busy;
  logic [31:0] s_data;
  logic        p_hold = 1'b0;
  logic [31:0] p_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_fifo();
    fifo_empty_flag = (fifo_q.size() == 0);
    fifo_rd_data    = fifo_empty_flag ? 32'h0 : fifo_q[0];
  endtask

  // Sample settled outputs mid-cycle, then advance to 1 time unit after the next edge.
  task automatic tick();
    #2;
    s_pop   = fifo_rd_en;
    s_valid = ser_valid;
    s_acc   = ser_valid & ser_ready;
    s_data  = ser_data;
    s_last  = ser_last;
    s_busy  = busy;
    if (p_hold) chk("hold_stable", ser_data, p_data);
    if (fifo_empty_flag) chk("no_underflow", {31'b0, fifo_rd_en}, 32'h0);
    p_hold = ser_valid & !ser_ready & !flush;
    p_data = ser_data;
    if (s_acc && !flush) got.push_back('{data: s_data, last: s_last});
    @(posedge fifo_clk);
    #1;
    if (s_pop) begin
      void'(fifo_q.pop_front());
      pops++;
    end
    drive_fifo();
  endtask

  // Reference: split a word into beats by plain arithmetic on lane slots.
  task automatic model_word(input logic [1:0] m, input logic be, input logic [31:0] w);
    int n;
    int bw;
    n  = (m == 2'd0) ? 4 : (m == 2'd1) ? 2 : 1;
    bw = 32 / n;
    for (int k = 0; k < n; k++) begin
      int          slot;
      logic [31:0] v;
      slot = be ? (n - 1 - k) : k;
      if (bw == 32) v = w;
      else v = (w >> (slot * bw)) & ((32'h1 << bw) - 32'h1);
      expq.push_back('{data: v, last: (k == n - 1)});
    end
  endtask

  task automatic set_vec(input int i, input logic [1:0] m, input logic be, input logic [31:0] w,
                         input logic [2:0] n, input logic [31:0] b0, input logic [31:0] b1,
                         input logic [31:0] b2, input logic [31:0] b3);
    vecs[i].mode = m;
    vecs[i].be   = be;
    vecs[i].word = w;
    vecs[i].n    = n;
    vecs[i].b[0] = b0;
    vecs[i].b[1] = b1;
    vecs[i].b[2] = b2;
    vecs[i].b[3] = b3;
  endtask

  initial begin
    int pops0;
    set_vec(0, 2'd0, 1'b0, 32'h44332211, 3'd4, 32'h11, 32'h22, 32'h33, 32'h44);
    set_vec(1, 2'd1, 1'b1, 32'hAABBCCDD, 3'd2, 32'hAABB, 32'hCCDD, 32'h0, 32'h0);
    set_vec(2, 2'd2, 1'b0, 32'hDEADBEEF, 3'd1, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0);
    set_vec(3, 2'd3, 1'b1, 32'h12345678, 3'd1, 32'h12345678, 32'h0, 32'h0, 32'h0);
    set_vec(4, 2'd0, 1'b1, 32'h04030201, 3'd4, 32'h04, 32'h03, 32'h02, 32'h01);
    set_vec(5, 2'd1, 1'b0, 32'h11223344, 3'd2, 32'h3344, 32'h1122, 32'h0, 32'h0);

    cfg_mode = 2'd0;
    cfg_big_endian = 1'b0;
    flush = 1'b0;
    ser_ready = 1'b0;
    fifo_q.push_back(32'h12345678);
    drive_fifo();

    // Reset state, with a non-empty FIFO to show no pop escapes during reset.
    #3;
    chk("rst_valid", {31'b0, ser_valid}, 32'h0);
    chk("rst_data", ser_data, 32'h0);
    chk("rst_last", {31'b0, ser_last}, 32'h0);
    chk("rst_cnt", {16'b0, word_cnt}, 32'h0);
    chk("rst_rd_en", {31'b0, fifo_rd_en}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h1);
    fifo_q.delete();
    drive_fifo();
    @(posedge fifo_clk);
    #1;
    fifo_rst_n = 1'b1;
    @(posedge fifo_clk);
    #1;

    // Table vectors, ready held high: one pop, then N consecutive beats.
    ser_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cfg_mode = vecs[i].mode;
      cfg_big_endian = vecs[i].be;
      fifo_q.push_back(vecs[i].word);
      drive_fifo();
      pops0 = pops;
      tick();
      chk("tbl_pop", {31'b0, s_pop}, 32'h1);
      chk("tbl_idle_valid", {31'b0, s_valid}, 32'h0);
      for (int k = 0; k < int'(vecs[i].n); k++) begin
        tick();
        chk("tbl_valid", {31'b0, s_valid}, 32'h1);
        chk("tbl_data", s_data, vecs[i].b[k]);
        chk("tbl_last", {31'b0, s_last}, {31'b0, (k == int'(vecs[i].n) - 1)});
      end
      exp_cnt++;
      chk("tbl_cnt", {16'b0, word_cnt}, {16'b0, exp_cnt});
      chk("tbl_one_pop", pops - pops0, 32'h1);
    end
    got.delete();

    // Back-to-back halfword big-endian words: no bubble, second pop on last accept.
    cfg_mode = 2'd1;
    cfg_big_endian = 1'b1;
    fifo_q.push_back(32'hAABBCCDD);
    fifo_q.push_back(32'h11223344);
    drive_fifo();
    tick();
    chk("b2b_pop0", {31'b0, s_pop}, 32'h1);
    tick();
    chk("b2b_d0", s_data, 32'hAABB);
    chk("b2b_pop1", {31'b0, s_pop}, 32'h0);
    tick();
    chk("b2b_d1", s_data, 32'hCCDD);
    chk("b2b_last1", {31'b0, s_last}, 32'h1);
    chk("b2b_pop2", {31'b0, s_pop}, 32'h1);
    tick();
    chk("b2b_d2", s_data, 32'h1122);
    chk("b2b_valid2", {31'b0, s_valid}, 32'h1);
    tick();
    chk("b2b_d3", s_data, 32'h3344);
    chk("b2b_last3", {31'b0, s_last}, 32'h1);
    tick();
    chk("b2b_idle", {31'b0, s_valid}, 32'h0);
    exp_cnt += 16'd2;
    chk("b2b_cnt", {16'b0, word_cnt}, {16'b0, exp_cnt});

    // Word mode with back-pressure: data held, exactly one pop.
    cfg_mode = 2'd2;
    cfg_big_endian = 1'b0;
    ser_ready = 1'b0;
    fifo_q.push_back(32'hDEADBEEF);
    drive_fifo();
    pops0 = pops;
    tick();
    tick();
    chk("bp_valid0", {31'b0, s_valid}, 32'h1);
    chk("bp_noacc", {31'b0, s_acc}, 32'h0);
    tick();
    chk("bp_hold", s_data, 32'hDEADBEEF);
    ser_ready = 1'b1;
    tick();
    chk("bp_acc", {31'b0, s_acc}, 32'h1);
    chk("bp_last", {31'b0, s_last}, 32'h1);
    chk("bp_data", s_data, 32'hDEADBEEF);
    tick();
    chk("bp_idle", {31'b0, s_valid}, 32'h0);
    chk("bp_pops", pops - pops0, 32'h1);
    exp_cnt++;
    chk("bp_cnt", {16'b0, word_cnt}, {16'b0, exp_cnt});

    // Empty FIFO: nothing happens.
    for (int c = 0; c < 10; c++) begin
      ser_ready = 1'($urandom_range(0, 1));
      tick();
      chk("empty_rd_en", {31'b0, s_pop}, 32'h0);
      chk("empty_valid", {31'b0, s_valid}, 32'h0);
      chk("empty_busy", {31'b0, s_busy}, 32'h0);
    end

    // Flush after beat 0x02: no pop during flush, word dropped, next word from lane 0.
    cfg_mode = 2'd0;
    cfg_big_endian = 1'b0;
    ser_ready = 1'b1;
    fifo_q.push_back(32'h04030201);
    drive_fifo();
    tick();
    tick();
    chk("fl_b0", s_data, 32'h01);
    tick();
    chk("fl_b1", s_data, 32'h02);
    fifo_q.push_back(32'h0D0C0B0A);
    drive_fifo();
    flush = 1'b1;
    tick();
    chk("fl_nopop", {31'b0, s_pop}, 32'h0);
    flush = 1'b0;
    tick();
    chk("fl_idle", {31'b0, s_valid}, 32'h0);
    chk("fl_pop", {31'b0, s_pop}, 32'h1);
    chk("fl_cnt", {16'b0, word_cnt}, {16'b0, exp_cnt});
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("fl_next", s_data, 32'h0A + 32'(k));
      chk("fl_next_last", {31'b0, s_last}, {31'b0, (k == 3)});
    end
    exp_cnt++;
    chk("fl_cnt2", {16'b0, word_cnt}, {16'b0, exp_cnt});

    // Asynchronous reset mid-word.
    fifo_q.push_back(32'h04030201);
    drive_fifo();
    tick();
    tick();
    chk("mr_b0", s_data, 32'h01);
    fifo_rst_n = 1'b0;
    #1;
    chk("mr_valid", {31'b0, ser_valid}, 32'h0);
    chk("mr_data", ser_data, 32'h0);
    chk("mr_last", {31'b0, ser_last}, 32'h0);
    chk("mr_cnt", {16'b0, word_cnt}, 32'h0);
    chk("mr_rd_en", {31'b0, fifo_rd_en}, 32'h0);
    fifo_q.delete();
    drive_fifo();
    p_hold = 1'b0;
    exp_cnt = '0;
    #3;
    fifo_rst_n = 1'b1;
    @(posedge fifo_clk);
    #1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("mr_after", {31'b0, s_valid}, 32'h0);
    end

    // Randomized segments against the beat model.
    for (int seg = 0; seg < 20; seg++) begin
      logic [1:0] m;
      logic       be;
      int         nw;
      int         cyc;
      m  = 2'($urandom_range(0, 3));
      be = 1'($urandom_range(0, 1));
      nw = $urandom_range(1, 5);
      cfg_mode = m;
      cfg_big_endian = be;
      got.delete();
      expq.delete();
      for (int w = 0; w < nw; w++) begin
        logic [31:0] wd;
        wd = $urandom;
        fifo_q.push_back(wd);
        model_word(m, be, wd);
      end
      drive_fifo();
      pops0 = pops;
      cyc = 0;
      while (got.size() < expq.size() && cyc < 200) begin
        ser_ready = 1'($urandom_range(0, 1));
        tick();
        cyc++;
      end
      chk("rand_beats", got.size(), expq.size());
      for (int i = 0; i < expq.size(); i++) begin
        if (i < got.size()) begin
          chk("rand_data", got[i].data, expq[i].data);
          chk("rand_last", {31'b0, got[i].last}, {31'b0, expq[i].last});
        end
      end
      chk("rand_pops", pops - pops0, nw);
      exp_cnt += 16'(nw);
      chk("rand_cnt", {16'b0, word_cnt}, {16'b0, exp_cnt});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fcb_rfu_rd_serializer.md
Name: fcb_rfu_rd_serializer

Overview:
- Read-side drain engine for the FCB 32-bit register-file FIFO; the FIFO is written with byte enables.
- Pops whole words from the FIFO and emits them as a lane-serialized stream: 1, 2 or 4 bytes per beat, over a valid/ready handshake toward the configuration shifter.
- Owns the FIFO read-enable. It is the only consumer of the FIFO read port.

Parameters:
- PAR_FIFO_DATA_WIDTH, 32, FIFO word width; fixed at 32 (4 byte lanes). Elaboration error otherwise.
- PAR_WCNT_WIDTH, 16, width of the drained-word counter.

Ports:
- fifo_clk  in  1  single clock.
- fifo_rst_n  in  1  reset; asynchronous, active-low.
- fifo_rd_data  in  32  FIFO head word; combinationally valid while fifo_empty_flag=0.
- fifo_empty_flag  in  1  FIFO empty.
- fifo_rd_en  out  1  pop strobe; FIFO advances its read pointer at the clock edge.
- cfg_mode  in  2  00=byte, 01=halfword, 10=word, 11=reserved (treated as word).
- cfg_big_endian  in  1  0: lowest byte lane first; 1: highest lane first.
- flush  in  1  synchronous discard of the held word.
- ser_data  out  32  beat data, right-aligned, upper bits zero.
- ser_valid  out  1  beat valid.
- ser_ready  in  1  downstream accept.
- ser_last  out  1  final beat of the current word.
- word_cnt  out  PAR_WCNT_WIDTH  words fully transmitted, wraps modulo 2^W.
- busy  out  1  ser_valid OR NOT fifo_empty_flag.

Behaviour:
- Reset (async assert, sync deassert at the next edge):
  - state=ST_IDLE; ser_valid=0, ser_data=0, ser_last=0, word_cnt=0.
  - hold_reg=0, lane_idx=0, mode_q=00, endian_q=0.
  - fifo_rd_en=0 while reset is asserted.
- Datapath: hold_reg (32b) plus mode_q/endian_q, latched only when a word is loaded. Mid-word changes to cfg_* have no effect until the next load.
- Beats per word N: 4 / 2 / 1 for mode 00 / 01 / 10(11). lane_idx is 0..N-1.
- Beat select:
  - Little-endian: beat k = hold_reg[(k+1)*B-1 : k*B], where B = 8 / 16 / 32.
  - Big-endian: beat k takes lane slot N-1-k.
- ser_data and ser_last are registered outputs. ser_last = (lane_idx == N-1) while ser_valid=1.
- States:
  - ST_IDLE (ser_valid=0): if fifo_empty_flag=0, assert fifo_rd_en combinationally, capture fifo_rd_data into hold_reg, lane_idx=0, go ST_SEND. ser_valid rises the next cycle, so IDLE-to-first-beat latency is 1 cycle.
  - ST_SEND (ser_valid=1): on ser_valid & ser_ready with a non-last beat, lane_idx+1 and present the next beat the following cycle.
  - ST_SEND, last beat accepted: word_cnt+1. If fifo_empty_flag=0, pop and load in the same cycle (zero-bubble back-to-back, stays ST_SEND). Otherwise go ST_IDLE with ser_valid=0.
- fifo_rd_en = (state==ST_IDLE & !fifo_empty_flag & !flush) | (last beat accepted & !fifo_empty_flag & !flush). It is never asserted when fifo_empty_flag=1 (no underflow).
- ser_valid/ser_data stable while ser_valid & !ser_ready.
- flush=1 (any state): next cycle state=ST_IDLE, ser_valid=0, lane_idx=0. No pop that cycle; the partially sent word is discarded and word_cnt is unchanged. An accept in the same cycle as flush is ignored.
- flush has priority over the handshake; reset has priority over everything.
- Reset mid-word: the held word is lost. The FIFO is on the same reset, so the system stays consistent.

Decomposition:
- Package fcb_rfu_rd_pkg:
  - enum state_t {ST_IDLE, ST_SEND}.
  - enum mode_t {MODE_B8=2'b00, MODE_B16=2'b01, MODE_B32=2'b10}.
  - Function beats_per_word(mode_t).
- One sub-module, fcb_rfu_lane_mux: combinational beat select from (hold_reg, mode_q, endian_q, lane_idx).
- The FSM, counters and handshake stay in the top module.

Test Plan:
- Mode 00, LE, FIFO holds 0x44332211, ser_ready=1 -> fifo_rd_en pulses once; beats 0x11, 0x22, 0x33, 0x44 on consecutive cycles; ser_last on 0x44; word_cnt=1.
- Mode 01, BE, words 0xAABBCCDD then 0x11223344 back-to-back -> beats 0xAABB, 0xCCDD, 0x1122, 0x3344 with no idle cycle between words; second fifo_rd_en coincident with the 0xCCDD accept; word_cnt=2.
- Mode 10, ser_ready toggling 1-0-1 on 0xDEADBEEF -> ser_data holds 0xDEADBEEF while ready=0; exactly one pop per word.
- Empty FIFO for 10 cycles -> fifo_rd_en=0, ser_valid=0, busy=0 throughout.
- Mode 00 word 0x04030201, flush after beat 0x02 accepted -> next cycle ser_valid=0; word_cnt unchanged; next FIFO word starts at lane 0.
- Async reset asserted mid-word (after beat 0x01) -> all outputs return to reset values immediately; after release with FIFO empty, no ser_valid.
